// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data/mult-div stall generation, D-stage forward select, mult/div busy tracker.
// Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [4:0] T_use_rs,
    input  logic [4:0] T_use_rt,
    input  logic [4:0] A3_E,
    input  logic [4:0] A3_M,
    input  logic [4:0] A3_W,
    input  logic [4:0] T_new_E,
    input  logic [4:0] T_new_M,
    input  logic [4:0] T_new_W,
    input  logic       md_start,
    input  logic       md_div,
    input  logic       md_use_D,
    output logic       stall,
    output logic       en_PC,
    output logic       en_D,
    output logic       clr_E,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    md_state_t  state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       data_stall, md_stall;

    // A source waits if a producer in E or M delivers later than the consumer needs it.
    function automatic logic data_hazard(
        input logic [4:0] src, input logic [4:0] t_use,
        input logic [4:0] a3_e, input logic [4:0] t_new_e,
        input logic [4:0] a3_m, input logic [4:0] t_new_m
    );
        return (src != 5'd0) &&
               (((src == a3_e) && (t_new_e > t_use)) ||
                ((src == a3_m) && (t_new_m > t_use)));
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] a3_e, input logic [4:0] t_new_e,
        input logic [4:0] a3_m, input logic [4:0] t_new_m,
        input logic [4:0] a3_w, input logic [4:0] t_new_w
    );
        if (src == 5'd0)                              return 2'd0;
        else if ((src == a3_e) && (t_new_e == 5'd0))  return 2'd1;
        else if ((src == a3_m) && (t_new_m == 5'd0))  return 2'd2;
        else if ((src == a3_w) && (t_new_w == 5'd0))  return 2'd3;
        else                                          return 2'd0;
    endfunction

    always_comb begin
        data_stall = data_hazard(rs_D, T_use_rs, A3_E, T_new_E, A3_M, T_new_M) |
                     data_hazard(rt_D, T_use_rt, A3_E, T_new_E, A3_M, T_new_M);
        md_stall   = md_use_D & (md_busy | md_start);
        stall      = data_stall | md_stall;
        en_PC      = ~stall;
        en_D       = ~stall;
        clr_E      = stall;
        fwd_rs_D   = fwd_sel(rs_D, A3_E, T_new_E, A3_M, T_new_M, A3_W, T_new_W);
        fwd_rt_D   = fwd_sel(rt_D, A3_E, T_new_E, A3_M, T_new_M, A3_W, T_new_W);
    end

    // Counter holds the remaining busy cycles; leaving BUSY coincides with it reaching 0.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_next = BUSY;
                    cnt_next   = md_div ? 4'd10 : 4'd5;
                end
            end
            BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign md_busy = (state == BUSY);

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) stall_cnt <= 32'd0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
